mem_port_arbiter: RTL

- Shares one single-port memory interface between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Arbitrates round-robin and latches the winning request, so memory-side signals stay stable for the whole transaction.
- Sequences the memory handshake, including variable latency and timeout, and returns read data plus a one-cycle ack to the owner.
- Sits between the CPU core and the unified memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 11 +
 rtl/mem_port_arbiter_rr_pick2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the two-port memory arbiter
package arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_FETCH = 1'b0;
    localparam owner_t OWNER_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       grant_valid,
    output owner_t     grant_owner
);

    // On a tie the port that did not win last time takes the grant.
    always_comb begin
        grant_valid = |req;
        grant_owner = OWNER_FETCH;
        if (req == 2'b11) begin
            grant_owner = ~last_owner;
        end else if (req[1]) begin
            grant_owner = OWNER_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err_sticky
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t    r_state;
    owner_t        r_owner;
    owner_t        r_last_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_busy;
    logic          r_err_sticky;
    logic [DW-1:0] r_rdata;
    logic          r_r0_ack;
    logic          r_r0_err;
    logic          r_r1_ack;
    logic          r_r1_err;

    logic          w_grant_valid;
    owner_t        w_grant_owner;
    logic          w_timeout;

    rr_pick2 u_pick (
        .req         ({r1_req, r0_req}),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_FETCH;
            r_last_owner <= OWNER_DATA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_err_sticky <= 1'b0;
            r_rdata      <= '0;
            r_r0_ack     <= 1'b0;
            r_r0_err     <= 1'b0;
            r_r1_ack     <= 1'b0;
            r_r1_err     <= 1'b0;
        end else begin
            r_r0_ack <= 1'b0;
            r_r0_err <= 1'b0;
            r_r1_ack <= 1'b0;
            r_r1_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= w_grant_owner;
                        r_we      <= (w_grant_owner == OWNER_DATA) ? r1_we    : r0_we;
                        r_addr    <= (w_grant_owner == OWNER_DATA) ? r1_addr  : r0_addr;
                        r_wdata   <= (w_grant_owner == OWNER_DATA) ? r1_wdata : r0_wdata;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A late mem_ack on the timeout cycle still counts as success.
                    if (mem_ack || w_timeout) begin
                        r_rdata   <= mem_ack ? mem_rdata : '0;
                        r_mem_req <= 1'b0;
                        r_r0_ack  <= (r_owner == OWNER_FETCH);
                        r_r1_ack  <= (r_owner == OWNER_DATA);
                        r_r0_err  <= (r_owner == OWNER_FETCH) && !mem_ack;
                        r_r1_err  <= (r_owner == OWNER_DATA) && !mem_ack;
                        if (!mem_ack) begin
                            r_err_sticky <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_last_owner <= r_owner;
                    r_cnt        <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign err_sticky = r_err_sticky;
    assign r0_ack     = r_r0_ack;
    assign r0_err     = r_r0_err;
    assign r1_ack     = r_r1_ack;
    assign r1_err     = r_r1_err;

endmodule
